// File: rtl/adc_acq_pkg.sv
// Shared definitions for the ADC acquisition sequencer.
// Contents: default widths, trigger-mode constants, FSM state enum.
package adc_acq_pkg;

    localparam int COUNT_W_DEF  = 32;
    localparam int SETTLE_W_DEF = 8;

    localparam logic TRIG_IMMEDIATE = 1'b0;
    localparam logic TRIG_EXTERNAL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        SETTLE  = 3'd2,
        ACQUIRE = 3'd3,
        DONE    = 3'd4
    } acq_state_e;

endpackage

// File: rtl/adc_acq_controller_if.sv
// Link between the acquisition sequencer and the ADC capture stage.
//   adc_enable     : sequencer -> capture stage, request samples
//   adc_data_valid : capture stage -> sequencer, one cycle after adc_enable
//   adc_otr_a/b    : raw over-range pins of channel A / B
// Handshake: the capture stage answers every cycle with adc_enable high by
// raising adc_data_valid exactly one cycle later; there is no back-pressure,
// so a valid is a completed transfer the moment it is seen.
interface adc_acq_controller_if;
    logic adc_enable;
    logic adc_data_valid;
    logic adc_otr_a;
    logic adc_otr_b;

    modport master (
        output adc_enable,
        input  adc_data_valid,
        input  adc_otr_a,
        input  adc_otr_b
    );

    modport slave (
        input  adc_enable,
        output adc_data_valid,
        output adc_otr_a,
        output adc_otr_b
    );
endinterface

// File: rtl/edge_detect_rise.sv
// Registered rising-edge detector.
//   clk, rst : clock, asynchronous active-high reset
//   d_i      : level input (already synchronous to clk)
//   rise_o   : one-cycle pulse, registered, one cycle after d_i goes 0->1
// RST_VAL sets the assumed previous level after reset; 1 means a level that is
// already high when reset releases is not reported as an edge.
module edge_detect_rise #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
        end else begin
            prev_q <= d_i;
            rise_q <= d_i & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/adc_acq_controller.sv
// Acquisition sequencer for the dual-channel ADC capture stage.
// Ports:
//   CLK_65, reset       : clock, asynchronous active-high reset
//   start, abort        : control pulses (abort wins over start)
//   trig_mode, trig_ext : 0 = immediate, 1 = wait for trig_ext rising edge
//   n_samples           : samples to deliver (latched at start)
//   settle_len          : warm-up samples to discard (latched at start)
//   adc                 : capture-stage link (enable / valid / over-range)
//   acq_valid           : downstream qualifier, valid while in ACQUIRE
//   sample_count        : acq_valid cycles since the last accepted start
//   busy, done          : status
//   overrange           : sticky over-range, bit0 = A, bit1 = B
//   state_o             : current FSM state for observation
module adc_acq_controller
    import adc_acq_pkg::*;
#(
    parameter int COUNT_W  = COUNT_W_DEF,
    parameter int SETTLE_W = SETTLE_W_DEF
) (
    input  logic                CLK_65,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                trig_mode,
    input  logic                trig_ext,
    input  logic [COUNT_W-1:0]  n_samples,
    input  logic [SETTLE_W-1:0] settle_len,
    adc_acq_controller_if.master adc,
    output logic                acq_valid,
    output logic [COUNT_W-1:0]  sample_count,
    output logic                busy,
    output logic                done,
    output logic [1:0]          overrange,
    output acq_state_e          state_o
);

    acq_state_e          state_q, state_d;
    logic [COUNT_W-1:0]  n_q, n_d;
    logic [SETTLE_W-1:0] settle_len_q, settle_len_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic [1:0]          ovr_q, ovr_d;
    logic [1:0]          otr_q;
    logic                en_prev_q;
    logic                adc_enable_c;
    logic                trig_rise;
    logic                start_ok;
    logic [COUNT_W:0]    pending;

    edge_detect_rise #(.RST_VAL(1'b1)) u_trig_edge (
        .clk    (CLK_65),
        .rst    (reset),
        .d_i    (trig_ext),
        .rise_o (trig_rise)
    );

    // trig_mode is consumed only in the accepting cycle; the chosen next
    // state (ARMED or not) is what carries it forward.
    assign start_ok = start && (state_q == IDLE || state_q == DONE);

    // Samples already received plus the one requested last cycle and still
    // in flight. Enable is withheld once these cover n_samples, so the
    // capture stage produces exactly settle_len + n_samples valids.
    assign pending = {1'b0, count_q} + {{COUNT_W{1'b0}}, en_prev_q};

    // ---------------- state register ----------------
    always_ff @(posedge CLK_65 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else if (start_ok) begin
            if (n_samples == '0) begin
                state_d = DONE;
            end else if (trig_mode == TRIG_EXTERNAL) begin
                state_d = ARMED;
            end else if (settle_len == '0) begin
                state_d = ACQUIRE;
            end else begin
                state_d = SETTLE;
            end
        end else begin
            case (state_q)
                ARMED: begin
                    if (trig_rise) begin
                        state_d = (settle_len_q == '0) ? ACQUIRE : SETTLE;
                    end
                end
                SETTLE: begin
                    if (adc.adc_data_valid &&
                        settle_cnt_q == settle_len_q - SETTLE_W'(1)) begin
                        state_d = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (acq_valid && count_q == n_q - COUNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        adc_enable_c = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        acq_valid    = 1'b0;
        case (state_q)
            ARMED: begin
                busy = 1'b1;
            end
            SETTLE: begin
                busy         = 1'b1;
                adc_enable_c = 1'b1;
            end
            ACQUIRE: begin
                busy         = 1'b1;
                adc_enable_c = (pending < {1'b0, n_q});
                acq_valid    = adc.adc_data_valid;
            end
            DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign adc.adc_enable = adc_enable_c;

    // ---------------- datapath next values ----------------
    always_comb begin
        n_d          = n_q;
        settle_len_d = settle_len_q;
        settle_cnt_d = settle_cnt_q;
        count_d      = count_q;
        ovr_d        = ovr_q;
        if (!abort && start_ok) begin
            n_d          = n_samples;
            settle_len_d = settle_len;
            settle_cnt_d = '0;
            count_d      = '0;
            ovr_d        = 2'b00;
        end else begin
            if (state_q == SETTLE && adc.adc_data_valid) begin
                settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
            end
            // A sample arriving in the abort cycle is still counted; abort
            // only redirects the FSM.
            if (acq_valid) begin
                count_d = count_q + COUNT_W'(1);
                ovr_d   = ovr_q | otr_q;
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge CLK_65 or posedge reset) begin
        if (reset) begin
            n_q          <= '0;
            settle_len_q <= '0;
            settle_cnt_q <= '0;
            count_q      <= '0;
            ovr_q        <= 2'b00;
            otr_q        <= 2'b00;
            en_prev_q    <= 1'b0;
        end else begin
            n_q          <= n_d;
            settle_len_q <= settle_len_d;
            settle_cnt_q <= settle_cnt_d;
            count_q      <= count_d;
            ovr_q        <= ovr_d;
            // One register stage lines the pins up with the capture data.
            otr_q        <= {adc.adc_otr_b, adc.adc_otr_a};
            en_prev_q    <= adc_enable_c;
        end
    end

    assign sample_count = count_q;
    assign overrange    = ovr_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_adc_acq_controller.sv
module tb_adc_acq_controller;
    import adc_acq_pkg::*;

    // ---------------- clock / reset ----------------
    logic        CLK_65 = 1'b0;
    logic        reset;
    logic        start, abort, trig_mode, trig_ext;
    logic [31:0] n_samples;
    logic [7:0]  settle_len;
    logic        acq_valid, busy, done;
    logic [31:0] sample_count;
    logic [1:0]  overrange;
    acq_state_e  state_o;
    logic        dv_q;
    logic        otr_a, otr_b;

    always #5 CLK_65 = ~CLK_65;

    adc_acq_controller_if ifc();

    adc_acq_controller #(.COUNT_W(32), .SETTLE_W(8)) dut (
        .CLK_65       (CLK_65),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .trig_mode    (trig_mode),
        .trig_ext     (trig_ext),
        .n_samples    (n_samples),
        .settle_len   (settle_len),
        .adc          (ifc.master),
        .acq_valid    (acq_valid),
        .sample_count (sample_count),
        .busy         (busy),
        .done         (done),
        .overrange    (overrange),
        .state_o      (state_o)
    );

    // Ideal capture stage: valid follows enable by one cycle.
    always @(posedge CLK_65 or posedge reset) begin
        if (reset) dv_q <= 1'b0;
        else       dv_q <= ifc.adc_enable;
    end
    assign ifc.adc_data_valid = dv_q;
    assign ifc.adc_otr_a      = otr_a;
    assign ifc.adc_otr_b      = otr_b;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int mon_en  = 0;
    int mon_val = 0;

    always @(negedge CLK_65) begin
        if (!reset) begin
            if (ifc.adc_enable) mon_en  = mon_en + 1;
            if (acq_valid)      mon_val = mon_val + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input logic [31:0] n, input logic [7:0] s, input logic m);
        @(negedge CLK_65);
        start = 1'b1; n_samples = n; settle_len = s; trig_mode = m;
        @(negedge CLK_65);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge CLK_65);
        end
    endtask

    typedef struct {
        int unsigned n;
        int unsigned s;
        int unsigned exp_en;
        int unsigned exp_val;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit ok;
        bit found;
        int pulses;

        start = 0; abort = 0; trig_mode = 0; trig_ext = 1'b1;
        n_samples = 0; settle_len = 0; otr_a = 0; otr_b = 0;
        reset = 1'b1;
        repeat (2) @(negedge CLK_65);

        check("rst_enable",   ifc.adc_enable, 0);
        check("rst_acqvalid", acq_valid, 0);
        check("rst_busy",     busy, 0);
        check("rst_done",     done, 0);
        check("rst_count",    64'(sample_count), 0);
        check("rst_ovr",      overrange, 0);
        check("rst_state",    64'(state_o), 64'(IDLE));
        reset = 1'b0;

        // ---- external trigger; trig_ext already high at reset must not fire
        mon_en = 0; mon_val = 0;
        pulse_start(4, 0, TRIG_EXTERNAL);
        repeat (3) @(negedge CLK_65);
        check("trig_stuck_high_armed", 64'(state_o), 64'(ARMED));
        trig_ext = 1'b0;
        repeat (20) @(negedge CLK_65);
        check("trig_wait_no_enable", mon_en, 0);
        check("trig_wait_busy", busy, 1);
        trig_ext = 1'b1;
        @(negedge CLK_65);
        check("trig_1edge_enable", ifc.adc_enable, 0);
        @(negedge CLK_65);
        check("trig_2edge_enable", ifc.adc_enable, 1);
        wait_done(50, ok);
        check("trig_done_seen", ok, 1);
        check("trig_valids", mon_val, 4);
        check("trig_count", 64'(sample_count), 4);
        check("trig_en_cycles", mon_en, 4);
        trig_ext = 1'b0;

        // ---- immediate-mode table: enable cycles = settle + n
        vecs[0] = '{n: 10, s: 3, exp_en: 13, exp_val: 10};
        vecs[1] = '{n: 1,  s: 0, exp_en: 1,  exp_val: 1};
        vecs[2] = '{n: 5,  s: 0, exp_en: 5,  exp_val: 5};
        vecs[3] = '{n: 3,  s: 1, exp_en: 4,  exp_val: 3};
        vecs[4] = '{n: 0,  s: 4, exp_en: 0,  exp_val: 0};
        vecs[5] = '{n: 7,  s: 2, exp_en: 9,  exp_val: 7};
        vecs[6] = '{n: 2,  s: 5, exp_en: 7,  exp_val: 2};
        for (int i = 0; i < 7; i++) begin
            mon_en = 0; mon_val = 0;
            pulse_start(vecs[i].n, 8'(vecs[i].s), TRIG_IMMEDIATE);
            wait_done(200, ok);
            check($sformatf("vec%0d_done", i), ok, 1);
            repeat (3) @(negedge CLK_65);
            check($sformatf("vec%0d_en", i), mon_en, vecs[i].exp_en);
            check($sformatf("vec%0d_val", i), mon_val, vecs[i].exp_val);
            check($sformatf("vec%0d_count", i), 64'(sample_count), 64'(vecs[i].n));
            check($sformatf("vec%0d_state", i), 64'(state_o), 64'(DONE));
        end

        // ---- zero length: DONE after one edge, no enable
        mon_en = 0; mon_val = 0;
        pulse_start(0, 2, TRIG_IMMEDIATE);
        check("zero_done", done, 1);
        check("zero_state", 64'(state_o), 64'(DONE));
        check("zero_no_enable", mon_en, 0);

        // ---- start while busy is ignored
        mon_en = 0; mon_val = 0;
        pulse_start(6, 4, TRIG_IMMEDIATE);
        check("busy_in_settle", 64'(state_o), 64'(SETTLE));
        start = 1'b1; n_samples = 2; settle_len = 0; trig_mode = TRIG_EXTERNAL;
        @(negedge CLK_65);
        start = 1'b0;
        check("busy_start_ignored", 64'(state_o), 64'(SETTLE));
        wait_done(100, ok);
        check("busy_done_seen", ok, 1);
        check("busy_count_kept", 64'(sample_count), 6);
        check("busy_en_cycles", mon_en, 10);

        // ---- over-range: A during SETTLE ignored, B during ACQUIRE captured
        pulse_start(8, 2, TRIG_IMMEDIATE);
        check("ovr_in_settle", 64'(state_o), 64'(SETTLE));
        otr_a = 1'b1;
        @(negedge CLK_65);
        otr_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (acq_valid && sample_count == 2) begin found = 1'b1; break; end
            @(negedge CLK_65);
        end
        check("ovr_reach_cnt2", found, 1);
        otr_b = 1'b1;
        @(negedge CLK_65);
        otr_b = 1'b0;
        wait_done(100, ok);
        check("ovr_done_seen", ok, 1);
        check("ovr_flags", overrange, 2'b10);
        pulse_start(3, 0, TRIG_IMMEDIATE);
        check("ovr_cleared", overrange, 0);
        check("ovr_count_cleared", 64'(sample_count), 0);
        wait_done(50, ok);
        check("ovr_second_done", ok, 1);
        check("ovr_second_flags", overrange, 0);

        // ---- abort at the 50th acq_valid
        pulse_start(100, 1, TRIG_IMMEDIATE);
        pulses = 0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (acq_valid) pulses++;
            if (pulses == 50) begin found = 1'b1; break; end
            @(negedge CLK_65);
        end
        check("abort_reach_50", found, 1);
        abort = 1'b1;
        @(negedge CLK_65);
        abort = 1'b0;
        check("abort_state", 64'(state_o), 64'(IDLE));
        check("abort_enable", ifc.adc_enable, 0);
        check("abort_count", 64'(sample_count), 50);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        // abort beats start in IDLE; nothing is cleared
        start = 1'b1; abort = 1'b1; n_samples = 9; settle_len = 0; trig_mode = 0;
        @(negedge CLK_65);
        start = 1'b0; abort = 1'b0;
        check("abort_over_start_state", 64'(state_o), 64'(IDLE));
        check("abort_over_start_count", 64'(sample_count), 50);

        // ---- asynchronous reset mid-ACQUIRE
        pulse_start(20, 0, TRIG_IMMEDIATE);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (acq_valid && sample_count == 2) begin found = 1'b1; break; end
            @(negedge CLK_65);
        end
        check("arst_reach_cnt2", found, 1);
        otr_a = 1'b1;
        @(negedge CLK_65);
        otr_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (sample_count == 5) begin found = 1'b1; break; end
            @(negedge CLK_65);
        end
        check("arst_reach_cnt5", found, 1);
        check("arst_pre_ovr", overrange, 2'b01);
        check("arst_pre_enable", ifc.adc_enable, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_enable",   ifc.adc_enable, 0);
        check("arst_acqvalid", acq_valid, 0);
        check("arst_busy",     busy, 0);
        check("arst_done",     done, 0);
        check("arst_count",    64'(sample_count), 0);
        check("arst_ovr",      overrange, 0);
        check("arst_state",    64'(state_o), 64'(IDLE));
        repeat (2) @(negedge CLK_65);
        reset = 1'b0;
        @(negedge CLK_65);
        check("arst_after_state", 64'(state_o), 64'(IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
